// File: rtl/demux_pkg.sv
// Shared constants for the 1-to-4 demux stage and its round-robin feeder.
package demux_pkg;
   localparam int   DEMUX_CH = 4;
   localparam int   SEL_W    = 2;
   localparam logic ST_IDLE  = 1'b0;
   localparam logic ST_HOLD  = 1'b1;
endpackage

// File: rtl/demux_rr_feeder_pick.sv
// Round-robin channel picker: first unmasked channel after last_sel, wrapping 3->0.
module rr_pick4
   import demux_pkg::*;
(
   input  logic [SEL_W-1:0]    last_sel,
   input  logic [DEMUX_CH-1:0] mask,
   output logic [SEL_W-1:0]    pick,
   output logic                any_en
);

   logic [SEL_W-1:0] idx;
   logic             found;

   // Offsets 1..4 so that last_sel itself is the final candidate.
   always_comb begin
      pick  = last_sel;
      found = 1'b0;
      idx   = '0;
      for (int i = 1; i <= DEMUX_CH; i++) begin
         idx = last_sel + SEL_W'(i);
         if (!found && !mask[idx]) begin
            pick  = idx;
            found = 1'b1;
         end
      end
   end

   assign any_en = ~&mask;

endmodule

// File: rtl/demux_rr_feeder.sv
// Valid/ready feeder that holds each word on dout/sel for HOLD_CYCLES clocks, rotating channels.
// DEMUX_FEEDER_B2B_EN: accept the next word in the last hold cycle, removing the idle gap.
module demux_rr_feeder
   import demux_pkg::*;
#(
   parameter int DATA_WIDTH  = 2,
   parameter int HOLD_CYCLES = 4
)(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DEMUX_CH-1:0]   skip_mask,
   output logic [DATA_WIDTH-1:0] dout,
   output logic [SEL_W-1:0]      sel,
   output logic                  dout_valid
);

   localparam int             CNT_W    = $clog2(HOLD_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(HOLD_CYCLES - 1);

   logic                  state_q;
   logic [CNT_W-1:0]      cnt_q;
   logic [DATA_WIDTH-1:0] dout_q;
   logic [SEL_W-1:0]      sel_q;
   logic                  vld_q;
   logic [SEL_W-1:0]      last_sel_q;

   logic [SEL_W-1:0]      pick_last;
   logic [SEL_W-1:0]      pick_ch;
   logic                  any_en;
   logic                  hold_done;
   logic                  xfer;

   assign hold_done = (cnt_q == '0);
   // In HOLD the only possible transfer is the back-to-back one, which rotates from the word on the bus.
   assign pick_last = (state_q == ST_HOLD) ? sel_q : last_sel_q;

   rr_pick4 u_pick (
      .last_sel (pick_last),
      .mask     (skip_mask),
      .pick     (pick_ch),
      .any_en   (any_en)
   );

   always_comb begin
      in_ready = 1'b0;
      if (state_q == ST_IDLE) begin
         in_ready = any_en;
      end
`ifdef DEMUX_FEEDER_B2B_EN
      else if (hold_done) begin
         in_ready = any_en;
      end
`endif
   end

   assign xfer = in_valid && in_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         dout_q     <= '0;
         sel_q      <= '0;
         vld_q      <= 1'b0;
         last_sel_q <= SEL_W'(DEMUX_CH - 1);
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (xfer) begin
                  dout_q  <= in_data;
                  sel_q   <= pick_ch;
                  vld_q   <= 1'b1;
                  cnt_q   <= CNT_INIT;
                  state_q <= ST_HOLD;
               end
            end
            default: begin
               if (hold_done) begin
                  last_sel_q <= sel_q;
                  if (xfer) begin
                     dout_q <= in_data;
                     sel_q  <= pick_ch;
                     cnt_q  <= CNT_INIT;
                  end else begin
                     dout_q  <= '0;
                     vld_q   <= 1'b0;
                     state_q <= ST_IDLE;
                  end
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
         endcase
      end
   end

   assign dout       = dout_q;
   assign sel        = sel_q;
   assign dout_valid = vld_q;

endmodule
